smult_acc: RTL
==============

Name: smult_acc

Overview:
- Downstream consumer of the 4-bit unsigned shift-add multiplier.
- Captures each 8-bit product when the multiplier controller pulses completion.
- Adds N_TERMS consecutive products into a dot-product sum, then presents the sum on a valid/ready output port.
- Stalls the upstream multiplier (prod_ready low) until the sum is accepted.

Parameters:
- N_TERMS, 4, number of products summed per output; legal range 1..15.
- ACC_WIDTH, 12, width of the accumulator and sum output; legal range 8..16.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clr  in  1  synchronous clear of the group in progress.
- prod_valid  in  1  one-cycle pulse: prod holds a finished product.
- prod  in  8  unsigned product from the multiplier datapath.
- prod_ready  out  1  high when a product can be accepted; upstream must not start a multiply while this is low.
- sum  out  ACC_WIDTH  completed group sum.
- sum_valid  out  1  sum and ovf are valid.
- sum_ready  in  1  downstream accepts sum.
- ovf  out  1  saturation occurred in this group; meaningful only while sum_valid is high.
- cnt  out  4  number of products accepted in the current group.

Behaviour:
- Reset values (asynchronous, immediate): state=ACC, acc=0, cnt=0, sum=0, sum_valid=0, ovf=0, internal ovf_acc=0. prod_ready=1 follows state.
- Priority: reset > clr > normal operation.
- State ACC:
  - prod_ready=1, sum_valid=0.
  - Product accept = prod_valid in ACC.
  - On accept: form a (ACC_WIDTH+1)-bit sum acc+zero-extended prod.
  - If the carry bit is set: result = all ones; set ovf_acc sticky for the group.
  - If cnt < N_TERMS-1: acc <= result, cnt <= cnt+1.
  - If cnt == N_TERMS-1: sum <= result, ovf <= ovf_acc | carry, sum_valid <= 1, acc <= 0, cnt <= 0, ovf_acc <= 0, state <= HOLD.
  - Latency: sum_valid rises on the clock edge that accepts the Nth product, i.e. visible the cycle after that prod_valid.
- State HOLD:
  - prod_ready=0, sum_valid=1.
  - sum and ovf are held stable.
  - prod_valid is ignored: no accumulation, cnt unchanged. Dropped pulses are an upstream protocol error, not flagged.
  - sum_ready=1 at an edge: sum_valid <= 0, ovf <= 0, state <= ACC. sum keeps its last value.
  - A prod_valid in the same cycle as that handshake is still ignored, because prod_ready was 0.
  - First new product can be accepted the cycle after the handshake.
- sum_ready while in ACC: no effect.
- clr (synchronous):
  - acc=0, cnt=0, ovf_acc=0, sum_valid=0, ovf=0, sum=0, state=ACC.
  - A simultaneous prod_valid is discarded.
  - A pending HOLD sum is discarded.
- N_TERMS=1: every accepted product goes directly to HOLD with sum=prod; ovf=0 (requires ACC_WIDTH>=8).
- cnt output equals the internal count, zero-extended to 4 bits.
- No combinational path from prod_valid or prod to any output. prod_ready and sum_valid are decoded from registered state only.

Test Plan:
- Default params; four prod_valid pulses with prod=0x48 (12*6=72), spaced 8 cycles -> cnt steps 1,2,3; sum=0x120 (288), sum_valid=1, ovf=0 the cycle after the 4th pulse; prod_ready=0.
- Hold sum_ready=0 for 6 cycles while pulsing prod_valid with prod=0xFF twice -> sum stays 0x120, cnt stays 0. Then sum_ready=1 for one cycle -> sum_valid=0, prod_ready=1. Next group of four 0x01 -> sum=0x004.
- ACC_WIDTH=9, N_TERMS=4, four products of 0xE1 (225) -> partial sums 225, 450, then saturate to 0x1FF. Result: sum=0x1FF, ovf=1. After handshake, next group of four 0x10 -> sum=0x040, ovf=0.
- Two products 0x30, then clr coinciding with a third prod_valid (prod=0x30), then four products 0x0A -> sum=0x028; clr-cycle product not counted.
- In HOLD with sum=0x120, assert reset asynchronously mid-cycle -> sum_valid=0, sum=0, cnt=0, prod_ready=1 without waiting for a clock edge. After release, four 0x02 -> sum=0x008.
- N_TERMS=1, prod=0xC6 -> sum=0x0C6, sum_valid=1 next cycle. prod_valid with sum_ready held 1 continuously -> one sum per accept, with prod_ready alternating 1/0.

Source files
------------

// File: rtl/smult_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : smult_acc_if
//  Description : Bundle of signals between the shift-add multiplier,
//                the product accumulator and the consumer of the group sum.
//                  master : environment side (drives products, clr, sum_ready)
//                  slave  : smult_acc side (drives prod_ready, sum, sum_valid,
//                           ovf, cnt)
//  Ports       : clr, prod_valid, prod[7:0], prod_ready,
//                sum[ACC_WIDTH-1:0], sum_valid, sum_ready, ovf, cnt[3:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface smult_acc_if #(
  parameter int ACC_WIDTH = 12
);
  logic                 clr;
  logic                 prod_valid;
  logic [7:0]           prod;
  logic                 prod_ready;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sum_valid;
  logic                 sum_ready;
  logic                 ovf;
  logic [3:0]           cnt;

  modport master (
    output clr, prod_valid, prod, sum_ready,
    input  prod_ready, sum, sum_valid, ovf, cnt
  );

  modport slave (
    input  clr, prod_valid, prod, sum_ready,
    output prod_ready, sum, sum_valid, ovf, cnt
  );
endinterface
`default_nettype wire

// File: rtl/smult_acc.sv
`default_nettype none
// ============================================================================
//  Module      : smult_acc
//  Description : Sums N_TERMS consecutive 8-bit products from the shift-add
//                multiplier into a saturating dot-product accumulator and
//                presents the result on a valid/ready port. The upstream
//                multiplier is stalled (prod_ready low) while a finished sum
//                waits to be taken.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous, active-high reset
//                bus    - smult_acc_if.slave (clr, product input handshake,
//                         sum output handshake, ovf flag, accepted count)
//  Revision    : 1.0  initial release
// ============================================================================
module smult_acc #(
  parameter int N_TERMS   = 4,
  parameter int ACC_WIDTH = 12
) (
  input  wire            clk,
  input  wire            reset,
  smult_acc_if.slave     bus
);

  localparam int         C_PAD  = ACC_WIDTH + 1 - 8;
  localparam logic [3:0] C_LAST = 4'(N_TERMS - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [3:0]           r_cnt;
  logic [ACC_WIDTH-1:0] r_sum;
  logic                 r_sum_valid;
  logic                 r_ovf;
  logic                 r_ovf_acc;

  logic [ACC_WIDTH:0]   w_add;
  logic                 w_carry;
  logic [ACC_WIDTH-1:0] w_result;

  // One extra bit catches the wrap; on carry the partial sum pins to all ones.
  assign w_add    = {1'b0, r_acc} + {{C_PAD{1'b0}}, bus.prod};
  assign w_carry  = w_add[ACC_WIDTH];
  assign w_result = w_carry ? {ACC_WIDTH{1'b1}} : w_add[ACC_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_ovf_acc   <= 1'b0;
    end else if (bus.clr) begin
      // Discards both a partial group and any sum waiting in HOLD.
      r_state     <= ST_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_ovf_acc   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (bus.prod_valid) begin
            if (r_cnt == C_LAST) begin
              r_sum       <= w_result;
              r_ovf       <= r_ovf_acc | w_carry;
              r_sum_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_ovf_acc   <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc       <= w_result;
              r_cnt       <= r_cnt + 4'd1;
              r_ovf_acc   <= r_ovf_acc | w_carry;
            end
          end
        end
        ST_HOLD: begin
          // Products arriving here are dropped: prod_ready is low.
          if (bus.sum_ready) begin
            r_sum_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_state     <= ST_ACC;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_sum_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = (r_state == ST_ACC);
  assign bus.sum        = r_sum;
  assign bus.sum_valid  = r_sum_valid;
  assign bus.ovf        = r_ovf;
  assign bus.cnt        = r_cnt;

endmodule
`default_nettype wire
